// File: rtl/fifo_rr_arbiter_if.sv
// ============================================================================
// Module      : fifo_rr_arbiter_if
// Description : Bundle of the requester-side and memory-side signals of the
//               FIFO round-robin arbiter.
//               master : arbiter view.
//                        Inputs  : req, req_data, mem_ready.
//                        Outputs : read_en, mem_valid, mem_wdata, mem_src, gnt.
//               slave  : environment view, which is the mirror image of master.
//               Optional feature macro of the arbiter: ARB_BURST_EN.
//               The interface itself does not depend on that macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_IDX    = 2,
  parameter int FIFO_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            read_en;
  logic                          mem_valid;
  logic                          mem_ready;
  logic [FIFO_WIDTH-1:0]         mem_wdata;
  logic [REQ_IDX-1:0]            mem_src;
  logic [NUM_REQ-1:0]            gnt;

  modport master (
    input  req, req_data, mem_ready,
    output read_en, mem_valid, mem_wdata, mem_src, gnt
  );

  modport slave (
    output req, req_data, mem_ready,
    input  read_en, mem_valid, mem_wdata, mem_src, gnt
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Round-robin arbiter that shares one memory write port among
//               NUM_REQ FIFO requesters.
//               The winning FIFO is popped through read_en.
//               Its head word is then held in a one-entry output register,
//               which drives the memory through a valid/ready handshake.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - fifo_rr_arbiter_if.master. Its signals are:
//                       req, req_data, read_en, mem_valid, mem_ready,
//                       mem_wdata, mem_src, gnt.
// Options     : ARB_BURST_EN - when defined, the previous winner may keep the
//               port for up to BURST_LEN consecutive grants.
//               When undefined, arbitration is strict round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_IDX    = 2,
  parameter int FIFO_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fifo_rr_arbiter_if.master   bus
);

  localparam logic [REQ_IDX-1:0] LAST_IDX = REQ_IDX'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                  mem_valid_q, mem_valid_d;
  logic [FIFO_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [REQ_IDX-1:0]    mem_src_q,   mem_src_d;
  logic [NUM_REQ-1:0]    gnt_q,       gnt_d;
  logic [REQ_IDX-1:0]    ptr_q,       ptr_d;

`ifdef ARB_BURST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  // mem_src only names a real previous winner once a grant has happened.
  // Without this flag, FIFO 0 would be treated as a burst continuation
  // straight after reset.
  logic                  last_vld_q,  last_vld_d;
  logic                  burst_hit;
`endif

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic                  load;
  logic                  rr_found;
  logic [REQ_IDX-1:0]    rr_win;
  logic [REQ_IDX-1:0]    win;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [REQ_IDX-1:0]    win_next_ptr;
  int                    scan_idx;

  // The output register can take a new word when it is empty or is being
  // drained this cycle, and only if somebody is requesting.
  assign load = (~mem_valid_q | bus.mem_ready) & (|bus.req);

  // Rotating priority scan: ptr, ptr+1, ..., wrapping at NUM_REQ-1.
  // The index is folded by subtraction, so a non-power-of-two NUM_REQ
  // wraps correctly.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!rr_found && bus.req[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = REQ_IDX'(scan_idx);
      end
    end
  end

`ifdef ARB_BURST_EN
  // The previous winner keeps the port while it still requests and its
  // burst is not exhausted. BURST_LEN=1 therefore never bursts.
  always_comb begin
    burst_hit = last_vld_q && bus.req[mem_src_q] &&
                (int'(burst_cnt_q) < (BURST_LEN - 1));
    win       = burst_hit ? mem_src_q : rr_win;
  end
`else
  assign win = rr_win;
`endif

  assign win_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
  assign win_next_ptr = (win == LAST_IDX) ? '0 : (win + REQ_IDX'(1));

  // The pop strobe is combinational and must stay quiet during reset,
  // so that FIFOs keep their data.
  assign bus.read_en = (rst_n && load) ? win_onehot : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_wdata_d = mem_wdata_q;
    mem_src_d   = mem_src_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
`ifdef ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
    last_vld_d  = last_vld_q;
`endif

    if (load) begin
      // A load either fills an empty register or refills it on the same
      // edge that the memory accepts the old word. That refill is what
      // gives back-to-back transfers with no bubble.
      mem_valid_d = 1'b1;
      mem_wdata_d = bus.req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
      mem_src_d   = win;
      gnt_d       = win_onehot;
`ifdef ARB_BURST_EN
      last_vld_d  = 1'b1;
      if (burst_hit) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end else begin
        burst_cnt_d = '0;
        ptr_d       = win_next_ptr;
      end
`else
      ptr_d       = win_next_ptr;
`endif
    end else if (mem_valid_q && bus.mem_ready) begin
      // The word was accepted and nothing replaces it.
      // mem_wdata deliberately keeps its last value.
      mem_valid_d = 1'b0;
      gnt_d       = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_src_q   <= '0;
      gnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_wdata_q <= mem_wdata_d;
      mem_src_q   <= mem_src_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_src   = mem_src_q;
  assign bus.gnt       = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_rr_arbiter
// Description : Directed self-checking bench for fifo_rr_arbiter.
//               dut4 is a 4-requester instance; dut3 is a 3-requester
//               instance that exercises the non-power-of-two wrap.
//               The burst sequence is compiled only when ARB_BURST_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fifo_rr_arbiter_if #(.NUM_REQ(4), .REQ_IDX(2), .FIFO_WIDTH(32)) bus4 ();
  fifo_rr_arbiter_if #(.NUM_REQ(3), .REQ_IDX(2), .FIFO_WIDTH(32)) bus3 ();

  fifo_rr_arbiter #(.NUM_REQ(4), .REQ_IDX(2), .FIFO_WIDTH(32), .BURST_LEN(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  fifo_rr_arbiter #(.NUM_REQ(3), .REQ_IDX(2), .FIFO_WIDTH(32), .BURST_LEN(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

`ifdef ARB_BURST_EN
  int exp_burst [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus4.req       = 4'b1111;
    bus4.req_data  = '0;
    bus4.mem_ready = 1'b0;
    bus3.req       = 3'b000;
    bus3.req_data  = '0;
    bus3.mem_ready = 1'b1;

    // Reset with every FIFO requesting: no pop and the outputs are cleared.
    #2;
    check_eq("rst_read_en", 32'(bus4.read_en), 32'h0);
    check_eq("rst_valid",   32'(bus4.mem_valid), 32'h0);
    check_eq("rst_gnt",     32'(bus4.gnt), 32'h0);
    check_eq("rst_wdata",   bus4.mem_wdata, 32'h0);
    check_eq("rst_src",     32'(bus4.mem_src), 32'h0);
    step();
    step();
    check_eq("rst_read_en_held", 32'(bus4.read_en), 32'h0);
    check_eq("rst_valid_held",   32'(bus4.mem_valid), 32'h0);
    bus4.req       = 4'b0000;
    bus4.mem_ready = 1'b1;
    rst_n          = 1'b1;
    step();
    check_eq("idle_valid", 32'(bus4.mem_valid), 32'h0);

    // Single requester with a near-all-ones word.
    bus4.req = 4'b0100;
    bus4.req_data[2*32 +: 32] = 32'hFFFF_FFFE;
    #1;
    check_eq("single_read_en", 32'(bus4.read_en), 32'h4);
    step();
    check_eq("single_valid", 32'(bus4.mem_valid), 32'h1);
    check_eq("single_src",   32'(bus4.mem_src), 32'h2);
    check_eq("single_gnt",   32'(bus4.gnt), 32'h4);
    check_eq("single_wdata", bus4.mem_wdata, 32'hFFFF_FFFE);
    bus4.req = 4'b0000;
    step();
    check_eq("drain_valid", 32'(bus4.mem_valid), 32'h0);
    check_eq("drain_gnt",   32'(bus4.gnt), 32'h0);
    check_eq("drain_wdata_kept", bus4.mem_wdata, 32'hFFFF_FFFE);

    // A reset pulse returns the pointer to 0; then all FIFOs request.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bus4.req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    bus4.req = 4'b1111;
    #1;
    check_eq("rr_read_en0", 32'(bus4.read_en), 32'h1);
    for (int n = 0; n < 6; n++) begin
      step();
      check_eq("rr_src",   32'(bus4.mem_src), 32'(n % 4));
      check_eq("rr_valid", 32'(bus4.mem_valid), 32'h1);
      check_eq("rr_wdata", bus4.mem_wdata, 32'hA000_0000 + 32'(n % 4));
      if (n < 5) check_eq("rr_read_en", 32'(bus4.read_en), 32'h1 << ((n + 1) % 4));
    end

    // Backpressure while FIFO 1 holds the register.
    bus4.mem_ready = 1'b0;
    #1;
    check_eq("bp_read_en0", 32'(bus4.read_en), 32'h0);
    for (int n = 0; n < 5; n++) begin
      step();
      check_eq("bp_gnt",     32'(bus4.gnt), 32'h2);
      check_eq("bp_wdata",   bus4.mem_wdata, 32'hA000_0001);
      check_eq("bp_valid",   32'(bus4.mem_valid), 32'h1);
      check_eq("bp_read_en", 32'(bus4.read_en), 32'h0);
    end
    bus4.mem_ready = 1'b1;
    #1;
    check_eq("bp_release_read_en", 32'(bus4.read_en), 32'h4);
    step();
    check_eq("bp_next_src",   32'(bus4.mem_src), 32'h2);
    check_eq("bp_next_wdata", bus4.mem_wdata, 32'hA000_0002);
    bus4.req = 4'b0000;
    step();
    check_eq("bp_drain_valid", 32'(bus4.mem_valid), 32'h0);

    // Wrap with three requesters: grant FIFO 1 first so that the pointer
    // lands on 2, then requests 0 and 1 must wrap around.
    for (int i = 0; i < 3; i++) bus3.req_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    bus3.req = 3'b010;
    #1;
    check_eq("wrap_read_en_a", 32'(bus3.read_en), 32'h2);
    step();
    check_eq("wrap_src_a", 32'(bus3.mem_src), 32'h1);
    bus3.req = 3'b011;
    #1;
    check_eq("wrap_read_en_b", 32'(bus3.read_en), 32'h1);
    step();
    check_eq("wrap_src_b",   32'(bus3.mem_src), 32'h0);
    check_eq("wrap_wdata_b", bus3.mem_wdata, 32'hB000_0000);
    check_eq("wrap_read_en_c", 32'(bus3.read_en), 32'h2);
    step();
    check_eq("wrap_src_c", 32'(bus3.mem_src), 32'h1);
    bus3.req = 3'b111;
    #1;
    check_eq("wrap_ptr_at_2", 32'(bus3.read_en), 32'h4);
    step();
    check_eq("wrap_src_d", 32'(bus3.mem_src), 32'h2);
    bus3.req = 3'b000;
    step();

`ifdef ARB_BURST_EN
    // Bursts of four grants alternate between the two requesters.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus4.req = 4'b0011;
    for (int n = 0; n < 9; n++) begin
      step();
      check_eq("burst_src", 32'(bus4.mem_src), 32'(exp_burst[n]));
    end
    // An asynchronous reset after the second grant drops the word at once.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check_eq("burst_r_src0", 32'(bus4.mem_src), 32'h0);
    step();
    check_eq("burst_r_src1", 32'(bus4.mem_src), 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("burst_r_valid",   32'(bus4.mem_valid), 32'h0);
    check_eq("burst_r_read_en", 32'(bus4.read_en), 32'h0);
    check_eq("burst_r_gnt",     32'(bus4.gnt), 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("burst_r_restart_read_en", 32'(bus4.read_en), 32'h1);
    step();
    check_eq("burst_r_restart_src", 32'(bus4.mem_src), 32'h0);
    bus4.req = 4'b0000;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
